// File: rtl/instr_loader_if.sv
// Host-pin and instruction-memory write bundle for instr_loader.
// The slave modport is the loader side; the master modport is the host/top-level side.
interface instr_loader_if #(
    parameter int unsigned ADDR_W = 7
);
    logic              load_mode;
    logic              byte_strobe;
    logic [7:0]        byte_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_run;
    logic [ADDR_W:0]   words_loaded;
    logic              err;

    modport master (
        output load_mode, byte_strobe, byte_data,
        input  mem_we, mem_addr, mem_wdata, cpu_run, words_loaded, err
    );

    modport slave (
        input  load_mode, byte_strobe, byte_data,
        output mem_we, mem_addr, mem_wdata, cpu_run, words_loaded, err
    );
endinterface

// File: rtl/instr_loader.sv
// Byte-serial loader: packs strobed bytes little-endian into words and writes them to imem.
// Define INSTR_LOADER_SYNC_EN to pass byte_strobe/load_mode through 2-FF synchronizers.
module instr_loader #(
    parameter int unsigned ADDR_W = 7
) (
    input logic           clk,
    input logic           rst_n,
    instr_loader_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StLoad, StWrite, StRun} state_e;

    localparam logic [ADDR_W:0] WordCap = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q, state_d;
    logic              strobe_s, mode_s, strobe_d_q, rise;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       lanes_q, lanes_d;
    logic [ADDR_W-1:0] widx_q, widx_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              err_q, err_d;

`ifdef INSTR_LOADER_SYNC_EN
    logic [1:0] strobe_sync_q, mode_sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            strobe_sync_q <= 2'b00;
            mode_sync_q   <= 2'b00;
        end else begin
            strobe_sync_q <= {strobe_sync_q[0], bus.byte_strobe};
            mode_sync_q   <= {mode_sync_q[0], bus.load_mode};
        end
    end

    assign strobe_s = strobe_sync_q[1];
    assign mode_s   = mode_sync_q[1];
`else
    assign strobe_s = bus.byte_strobe;
    assign mode_s   = bus.load_mode;
`endif

    assign rise = strobe_s & ~strobe_d_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            strobe_d_q  <= 1'b0;
            byte_cnt_q  <= 2'd0;
            lanes_q     <= 24'd0;
            widx_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            words_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            strobe_d_q  <= strobe_s;
            byte_cnt_q  <= byte_cnt_d;
            lanes_q     <= lanes_d;
            widx_q      <= widx_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            words_q     <= words_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        lanes_d     = lanes_q;
        widx_d      = widx_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        words_d     = words_q;
        err_d       = err_q;

        unique case (state_q)
            StIdle: begin
                if (mode_s) state_d = StLoad;
            end
            StLoad: begin
                // A strobe rise wins over a simultaneous mode drop; mode is seen next cycle.
                if (rise) begin
                    if (words_q == WordCap) begin
                        err_d = 1'b1;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        unique case (byte_cnt_q)
                            2'd0: lanes_d[7:0]   = bus.byte_data;
                            2'd1: lanes_d[15:8]  = bus.byte_data;
                            2'd2: lanes_d[23:16] = bus.byte_data;
                            2'd3: begin
                                mem_wdata_d = {bus.byte_data, lanes_q};
                                mem_addr_d  = widx_q;
                                state_d     = StWrite;
                            end
                            default: ;
                        endcase
                    end
                end else if (!mode_s) begin
                    if (byte_cnt_q != 2'd0) err_d = 1'b1;
                    byte_cnt_d = 2'd0;
                    state_d    = StRun;
                end
            end
            StWrite: begin
                widx_d     = widx_q + 1'b1;
                words_d    = words_q + 1'b1;
                byte_cnt_d = 2'd0;
                state_d    = StLoad;
            end
            StRun: begin
                if (mode_s) begin
                    widx_d     = '0;
                    words_d    = '0;
                    byte_cnt_d = 2'd0;
                    err_d      = 1'b0;
                    state_d    = StLoad;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.mem_we       = (state_q == StWrite);
    assign bus.cpu_run      = (state_q == StRun);
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.words_loaded = words_q;
    assign bus.err          = err_q;
endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench: drives two loaders (ADDR_W=7 and ADDR_W=2) with the same host stimulus
// and compares each against a byte-list reference model.
module tb_instr_loader;
    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode = 1'b0;
    logic       strobe = 1'b0;
    logic [7:0] data = 8'd0;

    int checks = 0;
    int errors = 0;

    logic [7:0] sess[$];
    wr_t        wq7[$];
    wr_t        wq2[$];

    always #5 clk = ~clk;

    instr_loader_if #(.ADDR_W(7)) h7 ();
    instr_loader_if #(.ADDR_W(2)) h2 ();

    assign h7.load_mode   = mode;
    assign h7.byte_strobe = strobe;
    assign h7.byte_data   = data;
    assign h2.load_mode   = mode;
    assign h2.byte_strobe = strobe;
    assign h2.byte_data   = data;

    instr_loader #(.ADDR_W(7)) u_dut7 (.clk(clk), .rst_n(rst_n), .bus(h7));
    instr_loader #(.ADDR_W(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(h2));

    always @(negedge clk) begin
        if (h7.mem_we === 1'b1) wq7.push_back('{int'(h7.mem_addr), h7.mem_wdata});
        if (h2.mem_we === 1'b1) wq2.push_back('{int'(h2.mem_addr), h2.mem_wdata});
    end

    // Reference model: what a session of bytes must produce for a memory of 'cap' words.
    function automatic int cap_of(int d);
        return (d == 0) ? 128 : 4;
    endfunction

    function automatic int exp_wl(int d);
        int w = sess.size() / 4;
        return (w > cap_of(d)) ? cap_of(d) : w;
    endfunction

    function automatic logic exp_err(int d);
        int n = sess.size();
        return logic'((n > 4 * cap_of(d)) || (n % 4 != 0));
    endfunction

    function automatic logic [31:0] exp_word(int i);
        return {sess[4*i+3], sess[4*i+2], sess[4*i+1], sess[4*i]};
    endfunction

    function automatic logic [31:0] obs_wl(int d);
        return (d == 0) ? 32'(h7.words_loaded) : 32'(h2.words_loaded);
    endfunction

    function automatic logic obs_err(int d);
        return (d == 0) ? h7.err : h2.err;
    endfunction

    function automatic logic obs_run(int d);
        return (d == 0) ? h7.cpu_run : h2.cpu_run;
    endfunction

    function automatic int wr_count(int d);
        return (d == 0) ? wq7.size() : wq2.size();
    endfunction

    function automatic wr_t get_wr(int d, int i);
        return (d == 0) ? wq7[i] : wq2[i];
    endfunction

    task automatic begin_session();
        mode = 1'b1;
        repeat (4) @(negedge clk);
        sess.delete();
        wq7.delete();
        wq2.delete();
    endtask

    task automatic end_session();
        mode = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        data   = b;
        strobe = 1'b1;
        repeat (4) @(negedge clk);
        strobe = 1'b0;
        repeat (4) @(negedge clk);
        sess.push_back(b);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({h7.mem_we, h7.mem_addr, h7.mem_wdata, h7.cpu_run, h7.words_loaded, h7.err} !== '0) begin
            errors++;
            $display("FAIL reset_dut7 outputs got %h want 0", {h7.mem_we, h7.mem_addr,
                     h7.mem_wdata, h7.cpu_run, h7.words_loaded, h7.err});
        end
        checks++;
        if ({h2.mem_we, h2.mem_addr, h2.mem_wdata, h2.cpu_run, h2.words_loaded, h2.err} !== '0) begin
            errors++;
            $display("FAIL reset_dut2 outputs got %h want 0", {h2.mem_we, h2.mem_addr,
                     h2.mem_wdata, h2.cpu_run, h2.words_loaded, h2.err});
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (h7.cpu_run !== 1'b0) begin
            errors++;
            $display("FAIL idle_cpu_run got %b want 0", h7.cpu_run);
        end
    endtask

    // Generic session: n random bytes, then every output checked against the model on both DUTs.
    task automatic test_load_session(input string name, input int n);
        begin_session();
        for (int k = 0; k < n; k++) send_byte(8'($urandom));
        end_session();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs_wl(d) !== 32'(exp_wl(d))) begin
                errors++;
                $display("FAIL %s dut%0d words_loaded got %0d want %0d", name, d, obs_wl(d),
                         exp_wl(d));
            end
            checks++;
            if (obs_err(d) !== exp_err(d)) begin
                errors++;
                $display("FAIL %s dut%0d err got %b want %b", name, d, obs_err(d), exp_err(d));
            end
            checks++;
            if (obs_run(d) !== 1'b1) begin
                errors++;
                $display("FAIL %s dut%0d cpu_run got %b want 1", name, d, obs_run(d));
            end
            checks++;
            if (wr_count(d) != exp_wl(d)) begin
                errors++;
                $display("FAIL %s dut%0d write_count got %0d want %0d", name, d, wr_count(d),
                         exp_wl(d));
            end
            for (int i = 0; i < wr_count(d) && i < exp_wl(d); i++) begin
                wr_t w = get_wr(d, i);
                checks++;
                if (w.addr != i || w.data !== exp_word(i)) begin
                    errors++;
                    $display("FAIL %s dut%0d write%0d got addr %0d data %h want addr %0d data %h",
                             name, d, i, w.addr, w.data, i, exp_word(i));
                end
            end
        end
    endtask

    task automatic test_single_word();
        logic [31:0] want = 32'h0010_0513;
        begin_session();
        send_byte(8'h13);
        send_byte(8'h05);
        send_byte(8'h10);
        send_byte(8'h00);
        end_session();
        checks++;
        if (wq7.size() != 1 || wq7[0].addr != 0 || wq7[0].data !== want) begin
            errors++;
            $display("FAIL single_word writes got %0d data %h want 1 at addr 0 data %h",
                     wq7.size(), (wq7.size() > 0) ? wq7[0].data : 32'hx, want);
        end
        checks++;
        if ({h7.words_loaded, h7.cpu_run, h7.err} !== {8'd1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL single_word status got wl %0d run %b err %b want 1 1 0",
                     h7.words_loaded, h7.cpu_run, h7.err);
        end
    endtask

    task automatic test_rerun();
        begin_session();
        checks++;
        if ({h7.cpu_run, h7.err, h7.words_loaded} !== '0) begin
            errors++;
            $display("FAIL rerun_clear got run %b err %b wl %0d want 0 0 0", h7.cpu_run, h7.err,
                     h7.words_loaded);
        end
        for (int k = 0; k < 4; k++) send_byte(8'($urandom));
        end_session();
        checks++;
        if (wq7.size() != 1 || wq7[0].addr != 0 || wq7[0].data !== exp_word(0) ||
            h7.err !== 1'b0) begin
            errors++;
            $display("FAIL rerun_write got n %0d data %h err %b want 1 %h 0", wq7.size(),
                     (wq7.size() > 0) ? wq7[0].data : 32'hx, h7.err, exp_word(0));
        end
    endtask

    task automatic test_reset_midload();
        begin_session();
        send_byte(8'($urandom));
        send_byte(8'($urandom));
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sess.delete();
        wq7.delete();
        wq2.delete();
        repeat (4) @(negedge clk);
        for (int k = 0; k < 4; k++) send_byte(8'($urandom));
        end_session();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (wr_count(d) != 1 || get_wr(d, 0).addr != 0 || get_wr(d, 0).data !== exp_word(0)
                || obs_err(d) !== 1'b0 || obs_wl(d) !== 32'd1) begin
                errors++;
                $display("FAIL reset_midload dut%0d got n %0d data %h err %b wl %0d want 1 %h 0 1",
                         d, wr_count(d), (wr_count(d) > 0) ? get_wr(d, 0).data : 32'hx,
                         obs_err(d), obs_wl(d), exp_word(0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_load_session("three_words", 12);
        test_load_session("partial", 6);
        test_rerun();
        test_load_session("overflow", 17);
        test_load_session("empty", 0);
        for (int r = 0; r < 4; r++) test_load_session("random", $urandom_range(1, 21));
        test_reset_midload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
